// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: issues word-aligned reads to
// instruction memory and presents each fetched word to decode with its PC.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            pc_redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            id_ready,
  output logic            instr_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] out_pc_value
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] redirect_pc;

  assign redirect_pc = redirect_target & ~XLEN'(3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      instr_q   <= NOP;
      out_pc_q  <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      out_pc_q  <= out_pc_d;
    end
  end

  // NOTE: every next-state signal gets a hold default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (pc_redirect) pc_d = redirect_pc;
      end
      REQ: begin
        if (pc_redirect) pc_d = redirect_pc;
        if (imem_ready) begin
          state_d = WAIT;
          // The accepted request targets the stale PC; its data must be dropped.
          if (pc_redirect) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (pc_redirect) pc_d = redirect_pc;
        if (imem_rvalid) begin
          if (discard_q || pc_redirect) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            instr_d  = imem_rdata;
            out_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = HOLD;
          end
        end else if (pc_redirect) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (pc_redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (id_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state_q == REQ);
    imem_addr    = pc_q;
    instr_valid  = (state_q == HOLD);
    instruction  = (state_q == HOLD) ? instr_q : NOP;
    out_pc_value = out_pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, with a
// program-order reference model feeding a scoreboard checked by a monitor.
module tb_instruction_fetch;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            pc_redirect = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;
  logic            id_ready = 1'b0;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] out_pc_value;

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_redirect    (pc_redirect),
    .redirect_target(redirect_target),
    .id_ready       (id_ready),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .out_pc_value   (out_pc_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural next-fetch PC and the one memory read in flight.
  logic [31:0] m_pc       = RESET_PC;
  bit          m_out      = 1'b0;
  bit          m_killed   = 1'b0;
  logic [31:0] m_out_addr = '0;
  int          stall_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit idr, input bit rdr, input logic [31:0] tgt);
    imem_ready      = rdy;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    id_ready        = idr;
    pc_redirect     = rdr;
    redirect_target = tgt;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) break;
    end
    check(name, 32'(imem_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(imem_req), 32'd0);
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_instr"},  instruction, NOP);
    check({tag, "_out_pc"}, out_pc_value, RESET_PC);
  endtask

  // Model: a delivered word advances the program by 4; any redirect replaces
  // the PC and kills whatever read is in flight or returning this cycle.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      m_pc      = RESET_PC;
      m_out     = 1'b0;
      m_killed  = 1'b0;
      stall_cnt = 0;
      exp_q.delete();
    end else begin
      stall_cnt++;
      if (imem_rvalid && m_out) begin
        m_out     = 1'b0;
        stall_cnt = 0;
        if (!m_killed && !pc_redirect) begin
          exp_q.push_back('{pc: m_out_addr, data: imem_rdata});
          m_pc = m_out_addr + 32'd4;
        end
        m_killed = 1'b0;
      end
      if (imem_req && imem_ready) begin
        check("single_outstanding", 32'(m_out), 32'd0);
        check("fetch_addr", imem_addr, m_pc);
        m_out      = 1'b1;
        m_killed   = 1'b0;
        m_out_addr = m_pc;
        stall_cnt  = 0;
      end
      if (pc_redirect) begin
        if (m_out) m_killed = 1'b1;
        m_pc = redirect_target & ~32'd3;
      end
      if (stall_cnt > 100) begin
        check("progress", 32'(stall_cnt), 32'd0);
        stall_cnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per presented instruction and polices
  // hold stability, NOP outside HOLD, and request timing after release.
  bit   prev_valid = 1'b0;
  bit   prev_hs    = 1'b0;
  exp_t held;
  always begin
    @(negedge clk);
    if (!rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) check("req_after_release", 32'(imem_req), 32'd1);
      if (instr_valid) begin
        check("no_req_in_hold", 32'(imem_req), 32'd0);
        if (!prev_valid) begin
          check("expected_available", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            held = exp_q.pop_front();
            check("instr", instruction, held.data);
            check("out_pc", out_pc_value, held.pc);
          end
        end else begin
          check("hold_instr_stable", instruction, held.data);
          check("hold_pc_stable", out_pc_value, held.pc);
        end
      end else begin
        check("nop_when_invalid", instruction, NOP);
        check("latency", 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_valid = instr_valid;
      prev_hs    = instr_valid && (id_ready || pc_redirect);
    end
  end

  initial begin
    drive(0, 0, '0, 0, 0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // First fetch after reset, then a 5-cycle decode stall.
    tick(); rst = 1'b1; drive(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("idle_no_req", 32'(imem_req), 32'd0);
    wait_req("a_req");
    check("a_addr", imem_addr, RESET_PC);
    tick(); drive(0, 1, 32'h0050_0093, 0, 0, '0);
    tick(); drive(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("a_valid", 32'(instr_valid), 32'd1);
    check("a_instr", instruction, 32'h0050_0093);
    check("a_out_pc", out_pc_value, 32'h0);
    repeat (5) tick();
    @(negedge clk);
    check("a_stall_valid", 32'(instr_valid), 32'd1);
    check("a_stall_instr", instruction, 32'h0050_0093);
    tick(); id_ready = 1'b1;
    tick(); id_ready = 1'b0;
    @(negedge clk);
    check("a_next_req", 32'(imem_req), 32'd1);
    check("a_next_addr", imem_addr, 32'h4);

    // Redirect while waiting: returning data dropped.
    tick(); imem_ready = 1'b1;
    tick(); drive(0, 0, '0, 0, 1, 32'h100);
    tick(); drive(0, 1, 32'hDEAD_BEEF, 0, 0, '0);
    tick(); drive(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("b_dropped", 32'(instr_valid), 32'd0);
    check("b_req", 32'(imem_req), 32'd1);
    check("b_addr", imem_addr, 32'h100);

    // Redirect in HOLD beats id_ready; misaligned target is aligned.
    tick(); imem_ready = 1'b1;
    tick(); drive(0, 1, 32'h1234_5678, 0, 0, '0);
    tick(); drive(0, 0, '0, 1, 1, 32'h203);
    @(negedge clk);
    check("c_presented", 32'(instr_valid), 32'd1);
    tick(); drive(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("c_valid_gone", 32'(instr_valid), 32'd0);
    check("c_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    tick(); drive(0, 0, '0, 0, 1, 32'hFFFF_FFFC);
    tick(); drive(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("d_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); drive(0, 1, 32'h00A0_0113, 0, 0, '0);
    tick(); drive(0, 0, '0, 1, 0, '0);
    @(negedge clk);
    check("d_out_pc", out_pc_value, 32'hFFFF_FFFC);
    tick(); drive(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    check("d_wrap_addr", imem_addr, 32'h0);

    // Reset during WAIT, then a stale rvalid.
    tick(); imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    check("e_wait_no_req", 32'(imem_req), 32'd0);
    tick(); rst = 1'b0;
    #1;
    check_reset_outputs("e_async");
    tick(); rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    tick(); imem_rvalid = 1'b0;
    @(negedge clk);
    check("e_stale_ignored", 32'(instr_valid), 32'd0);
    check("e_req", 32'(imem_req), 32'd1);
    check("e_addr", imem_addr, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      imem_ready  = ($urandom_range(0, 99) < 50);
      imem_rvalid = m_out ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
      imem_rdata  = m_out ? mem_word(m_out_addr) : $urandom;
      id_ready    = ($urandom_range(0, 99) < 50);
      pc_redirect = ($urandom_range(0, 99) < 4);
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
    end

    // Drain: no redirects, consume everything still in flight.
    for (int i = 0; i < 30; i++) begin
      tick();
      drive(i < 24, m_out, mem_word(m_out_addr), 1, 0, '0);
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
